// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared fetch/decode types and constants
package pipe_pkg;

    localparam int XLEN = 32;

    // Canonical RISC-V nop (addi x0,x0,0)
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_hazard_response_if.sv
// rtl/if_id_hazard_response_if.sv - hazard request / fetch-side response bundle
interface if_id_hazard_response_if;
    import pipe_pkg::*;

    logic            data_hazard;
    logic            if_flush;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] instr_in;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_instr;
    logic            if_id_valid;
    logic            pc_write;
    logic            if_id_write;
    logic            id_ex_bubble;
    logic [1:0]      state;
    logic            stall_err;
    logic            misalign_err;
    logic [31:0]     stall_cycles;
    logic [31:0]     flush_count;

    modport slave (
        input  data_hazard, if_flush, branch_target, instr_in,
        output pc_out, if_id_pc, if_id_instr, if_id_valid,
               pc_write, if_id_write, id_ex_bubble, state,
               stall_err, misalign_err, stall_cycles, flush_count
    );

    modport master (
        output data_hazard, if_flush, branch_target, instr_in,
        input  pc_out, if_id_pc, if_id_instr, if_id_valid,
               pc_write, if_id_write, id_ex_bubble, state,
               stall_err, misalign_err, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_stall_watchdog.sv
// rtl/hazard_stall_watchdog.sv - consecutive-stall run counter with sticky stall_err
module hazard_stall_watchdog #(
    parameter int MAX_STALL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic data_hazard,
    output logic stall_err
);

    localparam logic [7:0] MAX_RUN = 8'(MAX_STALL);

    logic [7:0] run_q;

    // Error flags on the edge where the run count reaches MAX_RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q     <= '0;
            stall_err <= 1'b0;
        end else if (!data_hazard) begin
            run_q <= '0;
        end else begin
            if (run_q != MAX_RUN) begin
                run_q <= run_q + 8'd1;
            end
            if (run_q >= MAX_RUN - 8'd1) begin
                stall_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_id_hazard_response.sv
// rtl/if_id_hazard_response.sv - PC and IF/ID register applying stall/flush/redirect; optional HAZARD_PERF_CNT_EN counters
module if_id_hazard_response
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int              MAX_STALL = 4
) (
    input logic                      clk,
    input logic                      reset,
    if_id_hazard_response_if.slave   bus
);

    logic [XLEN-1:0] pc_q;
    if_id_t          if_id_q;
    fetch_state_t    state_q;
    logic            misalign_q;
    logic            flush_acc;

    // A hazard masks any flush: the branch resolved with stale operands.
    assign flush_acc = bus.if_flush && !bus.data_hazard;

    always_comb begin
        bus.pc_write     = !bus.data_hazard;
        bus.if_id_write  = !bus.data_hazard;
        bus.id_ex_bubble = bus.data_hazard;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            if_id_q    <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
            state_q    <= RUN;
            misalign_q <= 1'b0;
        end else if (bus.data_hazard) begin
            state_q <= STALL;
        end else if (bus.if_flush) begin
            pc_q    <= bus.branch_target & ~32'h3;
            if_id_q <= '{pc: pc_q, instr: NOP_INSTR, valid: 1'b0};
            state_q <= FLUSH;
            if (bus.branch_target[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end
        end else begin
            pc_q    <= pc_q + 32'd4;
            if_id_q <= '{pc: pc_q, instr: bus.instr_in, valid: 1'b1};
            state_q <= RUN;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.if_id_pc     = if_id_q.pc;
    assign bus.if_id_instr  = if_id_q.instr;
    assign bus.if_id_valid  = if_id_q.valid;
    assign bus.state        = state_q;
    assign bus.misalign_err = misalign_q;

    hazard_stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .data_hazard (bus.data_hazard),
        .stall_err   (bus.stall_err)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.data_hazard && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_acc && flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
`else
    logic unused_flush_acc;
    assign unused_flush_acc = flush_acc;
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_if_id_hazard_response.sv
// tb/tb_if_id_hazard_response.sv - directed self-checking bench for if_id_hazard_response
module tb_if_id_hazard_response;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    if_id_hazard_response_if bus ();

    if_id_hazard_response dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.data_hazard   = 1'b0;
        bus.if_flush      = 1'b0;
        bus.branch_target = 32'h0;
        bus.instr_in      = 32'h0050_0093;
        reset             = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (bus.pc_out !== 32'h0) begin mismatched++; $display("FAIL reset_pc got %h exp %h", bus.pc_out, 32'h0); end
        compared++; if (bus.if_id_pc !== 32'h0) begin mismatched++; $display("FAIL reset_if_id_pc got %h exp %h", bus.if_id_pc, 32'h0); end
        compared++; if (bus.if_id_instr !== 32'h13) begin mismatched++; $display("FAIL reset_instr got %h exp %h", bus.if_id_instr, 32'h13); end
        compared++; if (bus.if_id_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", bus.if_id_valid); end
        compared++; if (bus.state !== 2'd0) begin mismatched++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        compared++; if ({bus.stall_err, bus.misalign_err} !== 2'b00) begin mismatched++; $display("FAIL reset_errs got %b exp 00", {bus.stall_err, bus.misalign_err}); end
        compared++; if ({bus.stall_cycles, bus.flush_count} !== 64'h0) begin mismatched++; $display("FAIL reset_counters got %h exp 0", {bus.stall_cycles, bus.flush_count}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_normal();
        step();
        compared++; if (bus.pc_out !== 32'h4) begin mismatched++; $display("FAIL normal_pc1 got %h exp %h", bus.pc_out, 32'h4); end
        compared++; if (bus.if_id_pc !== 32'h0) begin mismatched++; $display("FAIL normal_if_id_pc1 got %h exp %h", bus.if_id_pc, 32'h0); end
        compared++; if (bus.if_id_instr !== 32'h0050_0093) begin mismatched++; $display("FAIL normal_instr got %h exp %h", bus.if_id_instr, 32'h0050_0093); end
        compared++; if (bus.if_id_valid !== 1'b1) begin mismatched++; $display("FAIL normal_valid got %b exp 1", bus.if_id_valid); end
        compared++; if (bus.state !== 2'd0) begin mismatched++; $display("FAIL normal_state got %0d exp 0", bus.state); end
        step();
        compared++; if (bus.pc_out !== 32'h8) begin mismatched++; $display("FAIL normal_pc2 got %h exp %h", bus.pc_out, 32'h8); end
        compared++; if (bus.if_id_pc !== 32'h4) begin mismatched++; $display("FAIL normal_if_id_pc2 got %h exp %h", bus.if_id_pc, 32'h4); end
    endtask

    task automatic test_stall();
        bus.data_hazard = 1'b1;
        #1;
        compared++; if ({bus.pc_write, bus.if_id_write, bus.id_ex_bubble} !== 3'b001) begin mismatched++; $display("FAIL stall_enables got %b exp 001", {bus.pc_write, bus.if_id_write, bus.id_ex_bubble}); end
        step();
        compared++; if (bus.pc_out !== 32'h8) begin mismatched++; $display("FAIL stall_pc_hold got %h exp %h", bus.pc_out, 32'h8); end
        compared++; if (bus.if_id_pc !== 32'h4 || bus.if_id_valid !== 1'b1) begin mismatched++; $display("FAIL stall_if_id_hold got %h/%b exp 4/1", bus.if_id_pc, bus.if_id_valid); end
        compared++; if (bus.state !== 2'd1) begin mismatched++; $display("FAIL stall_state got %0d exp 1", bus.state); end
        bus.data_hazard = 1'b0;
        #1;
        compared++; if ({bus.pc_write, bus.if_id_write, bus.id_ex_bubble} !== 3'b110) begin mismatched++; $display("FAIL run_enables got %b exp 110", {bus.pc_write, bus.if_id_write, bus.id_ex_bubble}); end
        step();
        compared++; if (bus.pc_out !== 32'hC) begin mismatched++; $display("FAIL stall_resume_pc got %h exp %h", bus.pc_out, 32'hC); end
        compared++; if (bus.state !== 2'd0) begin mismatched++; $display("FAIL stall_resume_state got %0d exp 0", bus.state); end
    endtask

    task automatic test_flush();
        bus.if_flush      = 1'b1;
        bus.branch_target = 32'h40;
        #1;
        compared++; if ({bus.pc_write, bus.if_id_write, bus.id_ex_bubble} !== 3'b110) begin mismatched++; $display("FAIL flush_enables got %b exp 110", {bus.pc_write, bus.if_id_write, bus.id_ex_bubble}); end
        step();
        compared++; if (bus.pc_out !== 32'h40) begin mismatched++; $display("FAIL flush_pc got %h exp %h", bus.pc_out, 32'h40); end
        compared++; if (bus.if_id_instr !== 32'h13 || bus.if_id_valid !== 1'b0) begin mismatched++; $display("FAIL flush_if_id got %h/%b exp 00000013/0", bus.if_id_instr, bus.if_id_valid); end
        compared++; if (bus.if_id_pc !== 32'hC) begin mismatched++; $display("FAIL flush_if_id_pc got %h exp %h", bus.if_id_pc, 32'hC); end
        compared++; if (bus.state !== 2'd2) begin mismatched++; $display("FAIL flush_state got %0d exp 2", bus.state); end
        compared++; if (bus.misalign_err !== 1'b0) begin mismatched++; $display("FAIL flush_misalign got %b exp 0", bus.misalign_err); end
        compared++; if (bus.flush_count !== (PERF ? 32'd1 : 32'd0)) begin mismatched++; $display("FAIL flush_count1 got %0d exp %0d", bus.flush_count, PERF ? 1 : 0); end
        bus.if_flush = 1'b0;
    endtask

    task automatic test_hazard_and_flush();
        bus.data_hazard   = 1'b1;
        bus.if_flush      = 1'b1;
        bus.branch_target = 32'h80;
        #1;
        compared++; if ({bus.pc_write, bus.id_ex_bubble} !== 2'b01) begin mismatched++; $display("FAIL hf_enables got %b exp 01", {bus.pc_write, bus.id_ex_bubble}); end
        step();
        compared++; if (bus.pc_out !== 32'h40) begin mismatched++; $display("FAIL hf_pc_hold got %h exp %h", bus.pc_out, 32'h40); end
        compared++; if (bus.state !== 2'd1) begin mismatched++; $display("FAIL hf_state got %0d exp 1", bus.state); end
        compared++; if (bus.flush_count !== (PERF ? 32'd1 : 32'd0)) begin mismatched++; $display("FAIL hf_flush_count got %0d exp %0d", bus.flush_count, PERF ? 1 : 0); end
        bus.data_hazard = 1'b0;
        bus.if_flush    = 1'b0;
        step();
        compared++; if (bus.pc_out !== 32'h44 || bus.if_id_pc !== 32'h40 || bus.if_id_valid !== 1'b1) begin mismatched++; $display("FAIL hf_resume got pc %h if_id_pc %h v %b exp 44/40/1", bus.pc_out, bus.if_id_pc, bus.if_id_valid); end
    endtask

    task automatic test_back_to_back();
        bus.if_flush      = 1'b1;
        bus.branch_target = 32'h43;
        step();
        compared++; if (bus.pc_out !== 32'h40) begin mismatched++; $display("FAIL misalign_pc got %h exp %h", bus.pc_out, 32'h40); end
        compared++; if (bus.misalign_err !== 1'b1) begin mismatched++; $display("FAIL misalign_err got %b exp 1", bus.misalign_err); end
        bus.branch_target = 32'h100;
        step();
        compared++; if (bus.pc_out !== 32'h100 || bus.if_id_pc !== 32'h40) begin mismatched++; $display("FAIL b2b_flush got pc %h if_id_pc %h exp 100/40", bus.pc_out, bus.if_id_pc); end
        compared++; if (bus.state !== 2'd2) begin mismatched++; $display("FAIL b2b_state got %0d exp 2", bus.state); end
        compared++; if (bus.misalign_err !== 1'b1) begin mismatched++; $display("FAIL misalign_sticky got %b exp 1", bus.misalign_err); end
        bus.if_flush = 1'b0;
    endtask

    task automatic test_wrap();
        bus.if_flush      = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        step();
        compared++; if (bus.pc_out !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_setup got %h exp %h", bus.pc_out, 32'hFFFF_FFFC); end
        bus.if_flush = 1'b0;
        step();
        compared++; if (bus.pc_out !== 32'h0 || bus.if_id_pc !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap got pc %h if_id_pc %h exp 0/fffffffc", bus.pc_out, bus.if_id_pc); end
        compared++; if (bus.flush_count !== (PERF ? 32'd4 : 32'd0) || bus.stall_cycles !== (PERF ? 32'd2 : 32'd0)) begin mismatched++; $display("FAIL perf_counts got %0d/%0d exp %0d/%0d", bus.flush_count, bus.stall_cycles, PERF ? 4 : 0, PERF ? 2 : 0); end
    endtask

    task automatic test_watchdog();
        bus.data_hazard = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            compared++; if (bus.stall_err !== (i == 4)) begin mismatched++; $display("FAIL watchdog_edge%0d got %b exp %b", i, bus.stall_err, (i == 4)); end
        end
        compared++; if (bus.stall_cycles !== (PERF ? 32'd6 : 32'd0)) begin mismatched++; $display("FAIL stall_cycles got %0d exp %0d", bus.stall_cycles, PERF ? 6 : 0); end
        bus.data_hazard = 1'b0;
        step();
        compared++; if (bus.stall_err !== 1'b1 || bus.pc_out !== 32'h4) begin mismatched++; $display("FAIL watchdog_sticky got %b pc %h exp 1/4", bus.stall_err, bus.pc_out); end
        bus.data_hazard = 1'b1;
        step();
        #3;
        reset = 1'b1;
        #1;
        compared++; if (bus.pc_out !== 32'h0 || bus.state !== 2'd0 || bus.if_id_valid !== 1'b0) begin mismatched++; $display("FAIL async_reset got pc %h st %0d v %b exp 0/0/0", bus.pc_out, bus.state, bus.if_id_valid); end
        compared++; if ({bus.stall_err, bus.misalign_err} !== 2'b00 || bus.flush_count !== 32'h0) begin mismatched++; $display("FAIL async_reset_errs got %b fc %0d exp 00/0", {bus.stall_err, bus.misalign_err}, bus.flush_count); end
        @(negedge clk);
        reset           = 1'b0;
        bus.data_hazard = 1'b0;
        step();
        compared++; if (bus.pc_out !== 32'h4 || bus.if_id_pc !== 32'h0) begin mismatched++; $display("FAIL post_reset_fetch got pc %h if_id_pc %h exp 4/0", bus.pc_out, bus.if_id_pc); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_stall();
        test_flush();
        test_hazard_and_flush();
        test_back_to_back();
        test_wrap();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
